// File: rtl/ppcm_wb_arbiter.sv
// rtl/ppcm_wb_arbiter.sv - two-master round-robin Wishbone arbiter for wb_ppcm (optional PPCM_ARB_TIMEOUT_EN watchdog)
module ppcm_wb_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wbs0_cyc_i,
  input  logic                 wbs0_stb_i,
  input  logic [ADDR_BITS-1:0] wbs0_addr_i,
  input  logic [2:0]           wbs0_cti_i,
  input  logic [1:0]           wbs0_bte_i,
  input  logic [3:0]           wbs0_sel_i,
  input  logic                 wbs0_we_i,
  input  logic [31:0]          wbs0_data_i,
  output logic [31:0]          wbs0_data_o,
  output logic                 wbs0_ack_o,
  output logic                 wbs0_err_o,
  input  logic                 wbs1_cyc_i,
  input  logic                 wbs1_stb_i,
  input  logic [ADDR_BITS-1:0] wbs1_addr_i,
  input  logic [2:0]           wbs1_cti_i,
  input  logic [1:0]           wbs1_bte_i,
  input  logic [3:0]           wbs1_sel_i,
  input  logic                 wbs1_we_i,
  input  logic [31:0]          wbs1_data_i,
  output logic [31:0]          wbs1_data_o,
  output logic                 wbs1_ack_o,
  output logic                 wbs1_err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [ADDR_BITS-1:0] wbm_addr_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_data_o,
  input  logic [31:0]          wbm_data_i,
  input  logic                 wbm_ack_i,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   last_owner;
  logic   err_q;

  // Ownership FSM: a master keeps the bus for its whole cyc span; ties go to
  // the master that did not own last, so the two alternate under contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (wbs0_cyc_i && wbs1_cyc_i) begin
            if (last_owner) begin
              state <= OWN0;
              grant <= 2'b01;
            end else begin
              state <= OWN1;
              grant <= 2'b10;
            end
          end else if (wbs0_cyc_i) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (wbs1_cyc_i) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0: begin
          if (!wbs0_cyc_i) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b0;
          end
        end
        OWN1: begin
          if (!wbs1_cyc_i) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Bus steering: the owner's request reaches the slave and only the owner
  // sees the response; everything reads as zero while idle.
  always_comb begin
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_addr_o  = '0;
    wbm_cti_o   = 3'b000;
    wbm_bte_o   = 2'b00;
    wbm_sel_o   = 4'b0000;
    wbm_data_o  = 32'h0;
    wbs0_data_o = 32'h0;
    wbs0_ack_o  = 1'b0;
    wbs0_err_o  = 1'b0;
    wbs1_data_o = 32'h0;
    wbs1_ack_o  = 1'b0;
    wbs1_err_o  = 1'b0;
    case (state)
      OWN0: begin
        wbm_cyc_o   = wbs0_cyc_i;
        wbm_stb_o   = wbs0_stb_i;
        wbm_we_o    = wbs0_we_i;
        wbm_addr_o  = wbs0_addr_i;
        wbm_cti_o   = wbs0_cti_i;
        wbm_bte_o   = wbs0_bte_i;
        wbm_sel_o   = wbs0_sel_i;
        wbm_data_o  = wbs0_data_i;
        wbs0_data_o = wbm_data_i;
        wbs0_ack_o  = wbm_ack_i;
        wbs0_err_o  = err_q;
      end
      OWN1: begin
        wbm_cyc_o   = wbs1_cyc_i;
        wbm_stb_o   = wbs1_stb_i;
        wbm_we_o    = wbs1_we_i;
        wbm_addr_o  = wbs1_addr_i;
        wbm_cti_o   = wbs1_cti_i;
        wbm_bte_o   = wbs1_bte_i;
        wbm_sel_o   = wbs1_sel_i;
        wbm_data_o  = wbs1_data_i;
        wbs1_data_o = wbm_data_i;
        wbs1_ack_o  = wbm_ack_i;
        wbs1_err_o  = err_q;
      end
      default: begin
      end
    endcase
  end

`ifdef PPCM_ARB_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT + 1);

  logic [WD_BITS-1:0] wd_cnt;

  // Stall watchdog: counts strobed cycles without ack. Ownership changes
  // always pass through IDLE where cyc is low, which clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!(wbm_cyc_o && wbm_stb_o) || wbm_ack_i) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_BITS'(TIMEOUT - 1)) begin
        wd_cnt <= '0;
        err_q  <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WD_BITS'(1);
      end
    end
  end
`else
  // Watchdog compiled out: the error lines stay constant low.
  assign err_q = (TIMEOUT < 0);
`endif

endmodule
